// File: rtl/hamm_router_pipe.sv
// Three-stage Hamming(7,4) pipe: encode, optional single-bit error injection,
// then correct/decode and steer the nibble to one of NCH output channels.
module hamm_router_pipe #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int SW    = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SW-1:0]        in_sel,
   input  logic [3:0]           in_data,
   input  logic [2:0]           inj_pos,
   input  logic                 cnt_clr,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [4*NCH-1:0]     d_out,
   output logic [NCH-1:0]       err_flag,
   output logic [CNT_W*NCH-1:0] err_cnt
);

   // Handshake: a word moves on a rising edge when valid && ready are both high.
   // One shared advance enable drives every stage, so a stall anywhere holds all.
   logic             adv;
   logic             v1_q, v2_q, v3_q;
   logic [SW-1:0]    sel1_q, sel2_q, sel3_q;
   logic [6:0]       s1_cw_q, s2_cw_q;
   logic [6:0]       enc_d, inj_mask_d, s2_cw_d, fix_mask_d, fixed_d;
   logic [2:0]       syn_d;
   logic [3:0]       nib_d;
   logic [3:0]       dout_q [NCH];
   logic [NCH-1:0]   eflag_q;
   logic [CNT_W-1:0] cnt_q  [NCH];

   assign adv      = !v3_q || out_ready[sel3_q];
   assign in_ready = adv && !rst;

   // Bit [i-1] holds codeword position i: {d3,d2,d1,p4,d0,p2,p1}.
   always_comb begin
      enc_d[0] = in_data[0] ^ in_data[1] ^ in_data[3];
      enc_d[1] = in_data[0] ^ in_data[2] ^ in_data[3];
      enc_d[2] = in_data[0];
      enc_d[3] = in_data[1] ^ in_data[2] ^ in_data[3];
      enc_d[4] = in_data[1];
      enc_d[5] = in_data[2];
      enc_d[6] = in_data[3];
   end

   always_comb begin
      inj_mask_d = '0;
      if (inj_pos != 3'd0) inj_mask_d[inj_pos - 3'd1] = 1'b1;
      s2_cw_d = s1_cw_q ^ inj_mask_d;
   end

   // Syndrome {s4,s2,s1} names the flipped position directly.
   always_comb begin
      syn_d[0] = s2_cw_q[0] ^ s2_cw_q[2] ^ s2_cw_q[4] ^ s2_cw_q[6];
      syn_d[1] = s2_cw_q[1] ^ s2_cw_q[2] ^ s2_cw_q[5] ^ s2_cw_q[6];
      syn_d[2] = s2_cw_q[3] ^ s2_cw_q[4] ^ s2_cw_q[5] ^ s2_cw_q[6];
      fix_mask_d = '0;
      if (syn_d != 3'd0) fix_mask_d[syn_d - 3'd1] = 1'b1;
      fixed_d = s2_cw_q ^ fix_mask_d;
      nib_d   = {fixed_d[6], fixed_d[5], fixed_d[4], fixed_d[2]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         sel1_q  <= '0;
         sel2_q  <= '0;
         sel3_q  <= '0;
         s1_cw_q <= '0;
         s2_cw_q <= '0;
         eflag_q <= '0;
         for (int c = 0; c < NCH; c++) dout_q[c] <= '0;
      end else if (adv) begin
         v1_q    <= in_valid;
         sel1_q  <= in_sel;
         s1_cw_q <= enc_d;
         v2_q    <= v1_q;
         sel2_q  <= sel1_q;
         s2_cw_q <= s2_cw_d;
         v3_q    <= v2_q;
         sel3_q  <= sel2_q;
         if (v2_q) begin
            dout_q[sel2_q]  <= nib_d;
            eflag_q[sel2_q] <= (syn_d != 3'd0);
         end
      end
   end

   // Clear wins over a same-edge increment; counters stick at all-ones.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (rst || cnt_clr) begin
            cnt_q[c] <= '0;
         end else if (v3_q && (sel3_q == SW'(c)) && out_ready[c] && eflag_q[c]
                      && (cnt_q[c] != {CNT_W{1'b1}})) begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_out
      assign out_valid[c]             = v3_q && (sel3_q == SW'(c));
      assign d_out[4*c +: 4]          = dout_q[c];
      assign err_cnt[CNT_W*c +: CNT_W] = cnt_q[c];
   end
   assign err_flag = eflag_q;

endmodule

// File: tb/tb_hamm_router_pipe.sv
// Directed bench for hamm_router_pipe: a default instance plus a CNT_W=2 twin
// on the same stimulus for counter saturation.
module tb_hamm_router_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready, in_ready_s;
   logic [1:0] in_sel;
   logic [3:0] in_data;
   logic [2:0] inj_pos;
   logic       cnt_clr;
   logic [3:0] out_valid, out_valid_s;
   logic [3:0] out_ready;
   logic [15:0] d_out, d_out_s;
   logic [3:0] err_flag, err_flag_s;
   logic [31:0] err_cnt;
   logic [7:0]  err_cnt_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hamm_router_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .inj_pos(inj_pos), .cnt_clr(cnt_clr),
      .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
      .err_flag(err_flag), .err_cnt(err_cnt)
   );

   hamm_router_pipe #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_sel(in_sel), .in_data(in_data), .inj_pos(inj_pos), .cnt_clr(cnt_clr),
      .out_valid(out_valid_s), .out_ready(out_ready), .d_out(d_out_s),
      .err_flag(err_flag_s), .err_cnt(err_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge with the pipe empty; ends at the negedge the word is on the output.
   task automatic xfer(input int sel, input logic [3:0] data, input logic [2:0] inj);
      check("xfer_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_sel   = sel[1:0];
      in_data  = data;
      inj_pos  = inj;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("xfer_latency", out_valid, 0);
      @(negedge clk);
      check("xfer_route", out_valid, 32'(1) << sel);
      check("xfer_data", d_out[4*sel +: 4], data);
      check("xfer_eflag", err_flag[sel], (inj != 3'd0));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; inj_pos = '0;
      cnt_clr = 1'b0; out_ready = 4'hF;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_err_flag", err_flag, 0);
      check("rst_d_out", d_out, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_err_cnt_sat", err_cnt_s, 0);
      rst = 1'b0;
      @(negedge clk);

      // Encode/route of 1011 to channel 2
      check("enc_in_ready", in_ready, 1);
      in_valid = 1'b1; in_sel = 2'd2; in_data = 4'b1011; inj_pos = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check("enc_codeword", dut.s1_cw_q, 7'h55);
      @(negedge clk);
      check("enc_latency", out_valid, 0);
      @(negedge clk);
      check("enc_route", out_valid, 4'b0100);
      check("enc_data", d_out[11:8], 4'b1011);
      check("enc_eflag", err_flag[2], 0);
      @(negedge clk);

      // Single-error sweep on channel 1
      for (int d = 0; d < 16; d++)
         for (int p = 1; p < 8; p++)
            xfer(1, d[3:0], p[2:0]);
      @(negedge clk);
      check("sweep_cnt1", err_cnt[15:8], 112);
      check("sweep_cnt1_sat", err_cnt_s[3:2], 3);

      // Backpressure on channel 0
      inj_pos = 3'd0;
      check("bp_ready_pre", in_ready, 1);
      out_ready = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_sel = 2'd0; in_data = 4'(k + 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("bp_stall_ready", in_ready, 0);
         check("bp_stall_valid", out_valid, 4'b0001);
         check("bp_stall_data", d_out[3:0], 4'd1);
         @(negedge clk);
      end
      out_ready = 4'hF;
      @(negedge clk);
      check("bp_rel2_valid", out_valid, 4'b0001);
      check("bp_rel2_data", d_out[3:0], 4'd2);
      @(negedge clk);
      check("bp_rel3_valid", out_valid, 4'b0001);
      check("bp_rel3_data", d_out[3:0], 4'd3);
      @(negedge clk);
      check("bp_drained", out_valid, 0);
      check("bp_hold_data", d_out[3:0], 4'd3);

      // Saturation and clear on channel 3
      for (int k = 0; k < 5; k++) xfer(3, 4'(k + 5), 3'd3);
      @(negedge clk);
      check("sat_cnt3_narrow", err_cnt_s[7:6], 3);
      check("sat_cnt3_wide", err_cnt[31:24], 5);
      out_ready = 4'b0111;
      xfer(3, 4'hA, 3'd6);
      cnt_clr = 1'b1;
      out_ready = 4'hF;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_delivered", out_valid, 0);
      check("clr_cnt_wide", err_cnt, 0);
      check("clr_cnt_narrow", err_cnt_s, 0);

      // Reset with two corrected words in flight
      in_valid = 1'b1; in_sel = 2'd0; in_data = 4'd9; inj_pos = 3'd1;
      @(negedge clk);
      in_sel = 2'd1; in_data = 4'd6; inj_pos = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_valid", out_valid, 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("mid_rst_no_out", out_valid | out_valid_s, 0);
      end
      check("mid_rst_cnt", err_cnt, 0);
      check("mid_rst_cnt_sat", err_cnt_s, 0);
      check("mid_rst_d_out", d_out, 0);

      // Throughput: 16 back-to-back words round-robin
      inj_pos = 3'd5;
      for (int i = 0; i < 20; i++) begin
         if (i >= 3 && i < 19) begin
            check("tp_valid", out_valid, 32'(1) << ((i - 3) % 4));
            check("tp_data", d_out[4*((i - 3) % 4) +: 4], 32'(i - 3));
            check("tp_ready", in_ready, 1);
         end else begin
            check("tp_idle", out_valid, 0);
         end
         if (i < 16) begin
            in_valid = 1'b1; in_sel = 2'(i % 4); in_data = i[3:0];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("tp_cnt_wide", err_cnt, 32'h04040404);
      check("tp_cnt_narrow", err_cnt_s, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
